speck_decrypt_round_engine: RTL

SPECK_DECRYPT_ROUND_ENGINE -- requirements
Module: speck_decrypt_round_engine

---
 rtl/speck_decrypt_round_engine_if.sv | 24 ++
 rtl/speck_decrypt_round_engine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/speck_decrypt_round_engine_if.sv
// Handshake/bus bundle for the Speck128 decryption round engine.
// master: block that supplies ciphertext and round keys; slave: the engine.
interface speck_decrypt_round_engine_if;
   logic         start;
   logic [127:0] ciphertext;
   logic         key_req;
   logic [5:0]   key_round;
   logic [63:0]  round_key;
   logic         key_valid;
   logic [127:0] plaintext;
   logic         busy;
   logic         done;
   logic [3:0]   state_response;

   modport master (
      output start, ciphertext, round_key, key_valid,
      input  key_req, key_round, plaintext, busy, done, state_response
   );

   modport slave (
      input  start, ciphertext, round_key, key_valid,
      output key_req, key_round, plaintext, busy, done, state_response
   );
endinterface

// File: rtl/speck_decrypt_round_engine.sv
// Speck128 iterative decryption engine. Round keys are requested one at a time,
// last round first (key_round counts down from ROUNDS-1 to 0).
// Optional macro SPECK_DEC_SINGLE_CYCLE_ROUND_EN merges the two step states
// into one, giving 2 cycles per round instead of 3 with identical results.
module speck_decrypt_round_engine #(
   parameter int unsigned ROUNDS = 32
) (
   input logic                         clk,
   input logic                         rst,
   speck_decrypt_round_engine_if.slave bus
);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StLoad    = 4'd1,
      StWaitKey = 4'd2,
      StStepA   = 4'd3,
      StStepB   = 4'd4,
      StFinish  = 4'd5
   } state_e;

   localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

   state_e        state_q, state_d;
   logic [63:0]   x_q, x_d;
   logic [63:0]   y_q, y_d;
   logic [63:0]   k_q, k_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [127:0]  pt_q, pt_d;

   logic [63:0]   xy;
   logic [63:0]   y_rot;
   logic [63:0]   diff;
   logic [63:0]   x_rol;
   logic          key_req;
   logic          done;
   logic          busy;

   // Inverse-round datapath: y' = ROR3(x ^ y), x' = ROL8(x - y')
   always_comb begin
      xy    = x_q ^ y_q;
      y_rot = {xy[2:0], xy[63:3]};
`ifdef SPECK_DEC_SINGLE_CYCLE_ROUND_EN
      diff  = (x_q ^ k_q) - y_rot;
`else
      // In STEP_B, x already holds x ^ k and y holds the new y
      diff  = x_q - y_q;
`endif
      x_rol = {diff[55:0], diff[63:56]};
   end

   // Next-state and output decode
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      pt_d    = pt_q;
      key_req = 1'b0;
      done    = 1'b0;
      busy    = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               x_d     = bus.ciphertext[127:64];
               y_d     = bus.ciphertext[63:0];
               cnt_d   = LastRound;
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = StWaitKey;
         end
         StWaitKey: begin
            key_req = 1'b1;
            if (bus.key_valid) begin
               k_d     = bus.round_key;
               state_d = StStepA;
            end
         end
`ifdef SPECK_DEC_SINGLE_CYCLE_ROUND_EN
         StStepA: begin
            y_d = y_rot;
            x_d = x_rol;
            if (cnt_q == 6'd0) begin
               state_d = StFinish;
            end else begin
               cnt_d   = cnt_q - 6'd1;
               state_d = StWaitKey;
            end
         end
`else
         StStepA: begin
            y_d     = y_rot;
            x_d     = x_q ^ k_q;
            state_d = StStepB;
         end
         StStepB: begin
            x_d = x_rol;
            if (cnt_q == 6'd0) begin
               state_d = StFinish;
            end else begin
               cnt_d   = cnt_q - 6'd1;
               state_d = StWaitKey;
            end
         end
`endif
         StFinish: begin
            pt_d    = {x_q, y_q};
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any block in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         pt_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         pt_q    <= pt_d;
      end
   end

   // Counter returns to 0 at block end or reset, so key_round reads 0 in IDLE
   assign bus.key_req        = key_req;
   assign bus.key_round      = cnt_q;
   assign bus.plaintext      = pt_q;
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.state_response = state_q;

endmodule
